// File: rtl/delay_scan_seq.sv
// delay_scan_seq: steps the pulse-generator delay through an automatic
// sweep, committing each new delay only at a pulse-period boundary.
//
// Ports:
//   clk_pll, reset      : clock (rising edge), async active-high reset
//   start, abort        : one-cycle scan begin / scan stop requests
//   delay_static        : host delay used whenever no scan is running
//   delay_start/step    : first scan delay and unsigned per-point increment
//   n_points, n_avg     : number of points, periods held per point
//   period_end          : end-of-period strobe from the pulse generator
//   delay_out           : delay driven into the pulse generator
//   point_idx           : index of the current scan point
//   busy                : scan in progress (ARM, RUN or DONE)
//   point_done          : one-cycle pulse when a point's averaging completes
//   scan_done           : one-cycle pulse on normal completion
//   aborted             : one-cycle pulse when an abort is accepted
//   overflow            : sticky, delay saturated during the scan
module delay_scan_seq #(
  parameter int DW = 32,
  parameter int NW = 16,
  parameter int AW = 16
) (
  input  logic          clk_pll,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] delay_static,
  input  logic [DW-1:0] delay_start,
  input  logic [DW-1:0] delay_step,
  input  logic [NW-1:0] n_points,
  input  logic [AW-1:0] n_avg,
  input  logic          period_end,
  output logic [DW-1:0] delay_out,
  output logic [NW-1:0] point_idx,
  output logic          busy,
  output logic          point_done,
  output logic          scan_done,
  output logic          aborted,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Scan parameters frozen at start.
  logic [DW-1:0] p_start;
  logic [DW-1:0] p_step;
  logic [NW-1:0] p_npts;
  logic [AW-1:0] p_navg;

  logic [AW-1:0] avg_cnt;

  logic [DW-1:0] delay_d;
  logic [NW-1:0] idx_d;
  logic [AW-1:0] avg_d;
  logic          pdone_d;
  logic          sdone_d;
  logic          abrt_d;
  logic          ovf_d;
  logic          latch_en;

  logic          degen;
  logic          last_avg;
  logic          last_pt;
  logic [DW:0]   sum;

  // A zero count on either axis means there is nothing to sweep.
  assign degen    = (n_points == '0) || (n_avg == '0);
  assign last_avg = (avg_cnt == p_navg - AW'(1));
  assign last_pt  = (point_idx == p_npts - NW'(1));
  // Extra top bit catches the carry used for saturation.
  assign sum      = {1'b0, delay_out} + {1'b0, p_step};

  // State register.
  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Abort takes priority over a coincident period_end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !degen) begin
          state_d = ARM;
        end
      end
      ARM: begin
        if (abort) begin
          state_d = DONE;
        end else if (period_end) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = DONE;
        end else if (period_end && last_avg && last_pt) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (period_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    delay_d  = delay_out;
    idx_d    = point_idx;
    avg_d    = avg_cnt;
    pdone_d  = 1'b0;
    sdone_d  = 1'b0;
    abrt_d   = 1'b0;
    ovf_d    = overflow;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        delay_d = delay_static;
        if (start) begin
          latch_en = 1'b1;
          ovf_d    = 1'b0;
          sdone_d  = degen;
        end
      end
      ARM: begin
        if (abort) begin
          abrt_d = 1'b1;
        end else if (period_end) begin
          delay_d = p_start;
          idx_d   = '0;
          avg_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          abrt_d = 1'b1;
        end else if (period_end) begin
          if (!last_avg) begin
            avg_d = avg_cnt + AW'(1);
          end else begin
            pdone_d = 1'b1;
            avg_d   = '0;
            if (last_pt) begin
              sdone_d = 1'b1;
            end else begin
              idx_d = point_idx + NW'(1);
              if (sum[DW]) begin
                delay_d = '1;
                ovf_d   = 1'b1;
              end else begin
                delay_d = sum[DW-1:0];
              end
            end
          end
        end
      end
      DONE: begin
        if (period_end) begin
          delay_d = delay_static;
          idx_d   = '0;
        end
      end
      default: begin
        delay_d = delay_out;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      delay_out  <= '0;
      point_idx  <= '0;
      avg_cnt    <= '0;
      busy       <= 1'b0;
      point_done <= 1'b0;
      scan_done  <= 1'b0;
      aborted    <= 1'b0;
      overflow   <= 1'b0;
      p_start    <= '0;
      p_step     <= '0;
      p_npts     <= '0;
      p_navg     <= '0;
    end else begin
      delay_out  <= delay_d;
      point_idx  <= idx_d;
      avg_cnt    <= avg_d;
      busy       <= (state_d != IDLE);
      point_done <= pdone_d;
      scan_done  <= sdone_d;
      aborted    <= abrt_d;
      overflow   <= ovf_d;
      if (latch_en) begin
        p_start <= delay_start;
        p_step  <= delay_step;
        p_npts  <= n_points;
        p_navg  <= n_avg;
      end
    end
  end

endmodule
